// File: rtl/crossproduct_engine_if.sv
// Operand/result bundle for crossproduct_engine: operand handshake, result handshake, status.
// Purely structural; no latency of its own.
// Backpressure is carried by in_ready (engine -> source) and out_ready (sink -> engine).
// The optional dot-product output is present only when CROSSPRODUCT_DOT_EN is defined.
interface crossproduct_engine_if #(
    parameter int WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   a_x;
    logic signed [WIDTH-1:0]   a_y;
    logic signed [WIDTH-1:0]   a_z;
    logic signed [WIDTH-1:0]   b_x;
    logic signed [WIDTH-1:0]   b_y;
    logic signed [WIDTH-1:0]   b_z;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [2*WIDTH:0]   c_x;
    logic signed [2*WIDTH:0]   c_y;
    logic signed [2*WIDTH:0]   c_z;
    logic                      busy;
`ifdef CROSSPRODUCT_DOT_EN
    logic signed [2*WIDTH+1:0] dot;
`endif

    // Engine side
    modport slave (
        input  in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
`ifdef CROSSPRODUCT_DOT_EN
        output dot,
`endif
        output in_ready, out_valid, c_x, c_y, c_z, busy
    );

    // Operand source / result sink side
    modport master (
        output in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
`ifdef CROSSPRODUCT_DOT_EN
        input  dot,
`endif
        input  in_ready, out_valid, c_x, c_y, c_z, busy
    );
endinterface

// File: rtl/crossproduct_engine.sv
// Purpose: exact signed 3-D cross product a x b using one time-shared WIDTH x WIDTH multiplier.
// Latency: out_valid 7 cycles after the operand transfer (10 with CROSSPRODUCT_DOT_EN, which adds output dot).
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready, outputs kept afterwards.
module crossproduct_engine #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    crossproduct_engine_if.slave io
);
    localparam int PW = 2 * WIDTH;      // single product
    localparam int CW = 2 * WIDTH + 1;  // difference of two products
    localparam int AW = 2 * WIDTH + 2;  // sum of three products
`ifdef CROSSPRODUCT_DOT_EN
    localparam logic [3:0] LAST_STEP = 4'd8;
`else
    localparam logic [3:0] LAST_STEP = 4'd5;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              step_q;
    logic signed [WIDTH-1:0] ax_q, ay_q, az_q, bx_q, by_q, bz_q;
    logic signed [WIDTH-1:0] mul_a, mul_b;
    logic signed [PW-1:0]    prod;
    logic                    sub;
    logic signed [AW-1:0]    acc_q, acc_sum;
    logic signed [CW-1:0]    res_x_q, res_y_q;
    logic signed [CW-1:0]    c_x_q, c_y_q, c_z_q;
`ifdef CROSSPRODUCT_DOT_EN
    logic signed [CW-1:0]    res_z_q;
    logic signed [AW-1:0]    dot_q;
`endif

    // Select the operand pair for the current step; the only multiplier in the design follows
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step_q)
            4'd0: begin mul_a = ay_q; mul_b = bz_q; end
            4'd1: begin mul_a = az_q; mul_b = by_q; end
            4'd2: begin mul_a = az_q; mul_b = bx_q; end
            4'd3: begin mul_a = ax_q; mul_b = bz_q; end
            4'd4: begin mul_a = ax_q; mul_b = by_q; end
            4'd5: begin mul_a = ay_q; mul_b = bx_q; end
`ifdef CROSSPRODUCT_DOT_EN
            4'd6: begin mul_a = ax_q; mul_b = bx_q; end
            4'd7: begin mul_a = ay_q; mul_b = by_q; end
            4'd8: begin mul_a = az_q; mul_b = bz_q; end
`endif
            default: begin mul_a = '0; mul_b = '0; end
        endcase
    end

    assign prod    = PW'(mul_a) * PW'(mul_b);
    // Odd cross-product steps are the subtracted half of each component; dot steps always add
    assign sub     = (step_q < 4'd6) && step_q[0];
    assign acc_sum = sub ? (acc_q - AW'(prod)) : (acc_q + AW'(prod));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.in_valid) state_d = MUL;
            MUL:     if (step_q == LAST_STEP) state_d = DONE;
            DONE:    if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands, accumulate one product per cycle, publish results together
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q  <= '0;
            acc_q   <= '0;
            ax_q    <= '0; ay_q <= '0; az_q <= '0;
            bx_q    <= '0; by_q <= '0; bz_q <= '0;
            res_x_q <= '0;
            res_y_q <= '0;
            c_x_q   <= '0;
            c_y_q   <= '0;
            c_z_q   <= '0;
`ifdef CROSSPRODUCT_DOT_EN
            res_z_q <= '0;
            dot_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        ax_q   <= io.a_x; ay_q <= io.a_y; az_q <= io.a_z;
                        bx_q   <= io.b_x; by_q <= io.b_y; bz_q <= io.b_z;
                        acc_q  <= '0;
                        step_q <= '0;
                    end
                end
                MUL: begin
                    acc_q  <= acc_sum;
                    step_q <= step_q + 4'd1;
                    // Staging keeps the visible outputs at the previous result until this one is complete
                    if (step_q == 4'd1) begin
                        res_x_q <= CW'(acc_sum);
                        acc_q   <= '0;
                    end
                    if (step_q == 4'd3) begin
                        res_y_q <= CW'(acc_sum);
                        acc_q   <= '0;
                    end
`ifdef CROSSPRODUCT_DOT_EN
                    if (step_q == 4'd5) begin
                        res_z_q <= CW'(acc_sum);
                        acc_q   <= '0;
                    end
                    if (step_q == LAST_STEP) begin
                        c_x_q  <= res_x_q;
                        c_y_q  <= res_y_q;
                        c_z_q  <= res_z_q;
                        dot_q  <= acc_sum;
                        step_q <= '0;
                    end
`else
                    if (step_q == LAST_STEP) begin
                        c_x_q  <= res_x_q;
                        c_y_q  <= res_y_q;
                        c_z_q  <= CW'(acc_sum);
                        step_q <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q != IDLE);
    assign io.c_x       = c_x_q;
    assign io.c_y       = c_y_q;
    assign io.c_z       = c_z_q;
`ifdef CROSSPRODUCT_DOT_EN
    assign io.dot       = dot_q;
`endif
endmodule

// File: tb/tb_crossproduct_engine.sv
// Directed bench for crossproduct_engine: reset, vectors, backpressure, abort, back-to-back.
// Inputs driven and outputs sampled on the falling edge.
module tb_crossproduct_engine;
    localparam int W = 8;
`ifdef CROSSPRODUCT_DOT_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 7;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    crossproduct_engine_if #(.WIDTH(W)) io ();
    crossproduct_engine #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(io));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_ops(input int ax, input int ay, input int az, input int bx, input int by, input int bz);
        io.a_x = W'(ax); io.a_y = W'(ay); io.a_z = W'(az);
        io.b_x = W'(bx); io.b_y = W'(by); io.b_z = W'(bz);
    endtask

    // From a falling edge in IDLE: transfer one operand set, then wait for out_valid (bounded)
    task automatic run_op(input string tag, input int ax, input int ay, input int az,
                          input int bx, input int by, input int bz);
        int lat;
        chk({tag, "_in_ready"}, io.in_ready, 1);
        set_ops(ax, ay, az, bx, by, bz);
        io.in_valid = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b0;
        set_ops(99, -99, 42, -42, 17, -17);  // must not affect the operation in flight
        chk({tag, "_busy"}, io.busy, 1);
        lat = 1;
        while (!io.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
    endtask

    task automatic chk_res(input string tag, input int ex, input int ey, input int ez, input int ed);
        chk({tag, "_cx"}, io.c_x, ex);
        chk({tag, "_cy"}, io.c_y, ey);
        chk({tag, "_cz"}, io.c_z, ez);
`ifdef CROSSPRODUCT_DOT_EN
        chk({tag, "_dot"}, io.dot, ed);
`else
        if (ed == 12345) $display("unreachable");
`endif
    endtask

    initial begin
        int seen;
        int ops [4][6];
        int exps[4][4];
        ops[0] = '{1, 2, 3, 4, 5, 6};            exps[0] = '{-3, 6, -3, 32};
        ops[1] = '{5, 0, 0, 5, 0, 0};            exps[1] = '{0, 0, 0, 25};
        ops[2] = '{-7, 8, -9, 10, -11, 12};      exps[2] = '{-3, -6, -3, -266};
        ops[3] = '{127, -128, 127, -128, 127, -128}; exps[3] = '{255, 0, -255, -48768};

        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0);

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_busy", io.busy, 0);
        chk("rst_cx", io.c_x, 0);
        chk("rst_cz", io.c_z, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", io.in_ready, 1);

        // Basic vector
        io.out_ready = 1'b1;
        run_op("v123", 1, 2, 3, 4, 5, 6);
        chk_res("v123", -3, 6, -3, 32);
        @(negedge clk);
        chk("v123_one_cycle", io.out_valid, 0);
        chk("v123_idle", io.in_ready, 1);

        // Extreme negative operands
        run_op("vneg", -128, -128, 0, 127, -128, 0);
        chk_res("vneg", 0, 0, 32640, 128);
        @(negedge clk);
        chk("vneg_cx_kept", io.c_z, 32640);

        // Backpressure in DONE with a concurrent in_valid
        io.out_ready = 1'b0;
        run_op("bp", 3, -2, 7, -4, 5, 1);
        io.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", io.out_valid, 1);
            chk("bp_in_ready", io.in_ready, 0);
            chk_res("bp_hold", -37, -31, 7, -15);
            @(negedge clk);
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        chk("bp_still_valid", io.out_valid, 1);
        @(negedge clk);
        chk("bp_released", io.out_valid, 0);
        chk("bp_idle", io.in_ready, 1);
        chk_res("bp_kept", -37, -31, 7, -15);
        @(negedge clk);
        chk("bp_no_transfer", io.busy, 0);

        // Reset in the third MUL cycle
        set_ops(1, 1, 1, 2, 3, 4);
        io.in_valid = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", io.out_valid, 0);
        chk("abort_in_ready", io.in_ready, 1);
        chk("abort_busy", io.busy, 0);
        chk_res("abort_c", 0, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (io.out_valid) seen = 1;
        end
        chk("abort_no_result", seen, 0);
        chk_res("abort_c_after", 0, 0, 0, 0);

        // Back-to-back with in_valid and out_ready held high
        io.out_ready = 1'b1;
        set_ops(ops[0][0], ops[0][1], ops[0][2], ops[0][3], ops[0][4], ops[0][5]);
        io.in_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            int lat;
            if (k < 3) set_ops(ops[k+1][0], ops[k+1][1], ops[k+1][2], ops[k+1][3], ops[k+1][4], ops[k+1][5]);
            lat = 1;
            while (!io.out_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("b2b_latency", lat, LAT);
            chk_res("b2b", exps[k][0], exps[k][1], exps[k][2], exps[k][3]);
            @(negedge clk);
            chk("b2b_one_cycle", io.out_valid, 0);
            chk("b2b_in_ready", io.in_ready, 1);
            if (k == 3) io.in_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_final_idle", io.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
